// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS core: opcodes, functs, ALU ops
// and the decoded control word.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_write;
    logic    branch;
    logic    jump;
    alu_op_e alu_op;
  } ctrl_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_control.sv
// Main decoder: opcode/funct to control word. Anything not recognised
// decodes to an all-zero word, which behaves as a NOP.
module mips_control
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          default: begin
            ctrl.reg_dst   = 1'b0;
            ctrl.reg_write = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_J:    ctrl.jump = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mem.sv
// Storage blocks of the core. None of them is reset so that contents can be
// preloaded and survive a mid-run reset. Depths must be powers of two.
module mips_instmem #(
  parameter int WORDS = 64,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   rdata
);
  logic [31:0] Mem [0:WORDS-1];

  assign rdata = Mem[addr];
endmodule

module mips_regfile (
  input  logic        clock,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] reg_mem [0:31];

  // $0 is hardwired: writes are dropped and reads forced to zero
  always_ff @(posedge clock) begin
    if (we && waddr != 5'd0) reg_mem[waddr] <= wdata;
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : reg_mem[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : reg_mem[ra2];
endmodule

module mips_datamem #(
  parameter int WORDS = 64,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] Mem [0:WORDS-1];

  always_ff @(posedge clock) begin
    if (we) Mem[addr] <= wdata;
  end

  assign rdata = Mem[addr];
endmodule

// File: rtl/mips_cpu.sv
// Single-cycle MIPS core top. Define MIPS_TRACE_EN to get a simulation-only
// per-instruction retirement trace.
module mips_cpu
  import mips_pkg::*;
#(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input logic clock,
  input logic reset
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr, imm_ext, pc_plus4;
  logic [31:0] rs_val, rt_val, alu_b, alu_result, mem_rdata, wb_data;
  logic [4:0]  wr_reg;
  logic        reg_we, mem_we;
  ctrl_t       ctrl;

  mips_instmem #(.WORDS(IMEM_WORDS)) instmem_0 (
    .addr  (pc_q[IAW+1:2]),
    .rdata (instr)
  );

  mips_control control_0 (
    .op    (instr[31:26]),
    .funct (instr[5:0]),
    .ctrl  (ctrl)
  );

  // No architectural writes happen on edges while reset is held
  assign reg_we  = ctrl.reg_write & ~reset;
  assign mem_we  = ctrl.mem_write & ~reset;
  assign imm_ext = sext16(instr[15:0]);
  assign wr_reg  = ctrl.reg_dst ? instr[15:11] : instr[20:16];
  assign alu_b   = ctrl.alu_src ? imm_ext : rt_val;
  assign wb_data = ctrl.mem_to_reg ? mem_rdata : alu_result;

  mips_regfile regfile_0 (
    .clock (clock),
    .we    (reg_we),
    .waddr (wr_reg),
    .wdata (wb_data),
    .ra1   (instr[25:21]),
    .ra2   (instr[20:16]),
    .rd1   (rs_val),
    .rd2   (rt_val)
  );

  always_comb begin
    alu_result = rs_val + alu_b;
    case (ctrl.alu_op)
      ALU_ADD: alu_result = rs_val + alu_b;
      ALU_SUB: alu_result = rs_val - alu_b;
      ALU_AND: alu_result = rs_val & alu_b;
      ALU_OR:  alu_result = rs_val | alu_b;
      ALU_SLT: alu_result = {31'd0, $signed(rs_val) < $signed(alu_b)};
      default: alu_result = rs_val + alu_b;
    endcase
  end

  mips_datamem #(.WORDS(DMEM_WORDS)) data_memory_0 (
    .clock (clock),
    .we    (mem_we),
    .addr  (alu_result[DAW+1:2]),
    .wdata (rt_val),
    .rdata (mem_rdata)
  );

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    pc_d     = pc_plus4;
    if (ctrl.jump)
      pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (ctrl.branch && rs_val == rt_val)
      pc_d = pc_plus4 + {imm_ext[29:0], 2'b00};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pc_q <= 32'd0;
    else       pc_q <= pc_d;
  end

  logic unused_bits;
  assign unused_bits = ^{instr[10:6], alu_result[1:0], alu_result[31:DAW+2]};

`ifdef MIPS_TRACE_EN
  always @(posedge clock) begin
    if (!reset) begin
      $display("[TRACE] t=%0t pc=%08h instr=%08h", $time, pc_q, instr);
      if (reg_we && wr_reg != 5'd0)
        $display("[TRACE]   wb r%0d=%08h", wr_reg, wb_data);
      if (mem_we)
        $display("[TRACE]   st [%08h]=%08h", alu_result, rt_val);
    end
  end
`endif

endmodule

// File: tb/tb_mips_cpu.sv
// Self-checking bench for mips_cpu: a directed program table plus random
// programs compared against an instruction-level model.
module tb_mips_cpu;

  logic clock;
  logic reset;

  int tests_run;
  int tests_failed;

  logic [31:0] m_reg  [32];
  logic [31:0] m_dmem [64];
  logic [31:0] m_imem [64];
  logic [31:0] m_pc;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    int          kind;   // 0 register, 1 data word, 2 PC only
    int          idx;
    logic [31:0] val;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs [11];

  mips_cpu #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
    .clock (clock),
    .reset (reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 64; i++) begin
      dut.instmem_0.Mem[i]     = 32'd0;
      dut.data_memory_0.Mem[i] = 32'd0;
      m_imem[i] = 32'd0;
      m_dmem[i] = 32'd0;
    end
    for (int i = 0; i < 32; i++) begin
      dut.regfile_0.reg_mem[i] = 32'd0;
      m_reg[i] = 32'd0;
    end
  endtask

  // Instruction-level reference: one call retires one instruction
  task automatic model_step();
    logic [31:0] ins, a, b, simm, npc, ea;
    int op, rs, rt, rd, fn;
    ins  = m_imem[(m_pc / 4) % 64];
    op   = int'(ins >> 26);
    rs   = int'((ins >> 21) & 32'h1F);
    rt   = int'((ins >> 16) & 32'h1F);
    rd   = int'((ins >> 11) & 32'h1F);
    fn   = int'(ins & 32'h3F);
    simm = (ins & 32'h8000) != 0 ? ((ins & 32'hFFFF) | 32'hFFFF0000) : (ins & 32'hFFFF);
    a    = m_reg[rs];
    b    = m_reg[rt];
    npc  = m_pc + 4;
    ea   = a + simm;
    case (op)
      0: case (fn)
        'h20: m_reg[rd] = a + b;
        'h22: m_reg[rd] = a - b;
        'h24: m_reg[rd] = a & b;
        'h25: m_reg[rd] = a | b;
        'h2A: m_reg[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: ;
      endcase
      'h08: m_reg[rt] = ea;
      'h23: m_reg[rt] = m_dmem[(ea / 4) % 64];
      'h2B: m_dmem[(ea / 4) % 64] = b;
      'h04: if (a == b) npc = m_pc + 4 + simm * 4;
      'h02: npc = ((m_pc + 4) & 32'hF0000000) | ((ins & 32'h03FFFFFF) * 4);
      default: ;
    endcase
    m_reg[0] = 32'd0;
    m_pc = npc;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [5:0]  fns [5];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    fn  = fns[$urandom_range(0, 4)];
    case ($urandom_range(0, 9))
      0, 1, 2: return {6'h00, rs, rt, rd, 5'd0, fn};
      3:       return {6'h08, rs, rt, imm};
      4:       return {6'h23, rs, rt, imm};
      5:       return {6'h2B, rs, rt, imm};
      6: begin
        imm = 16'($urandom_range(0, 6)) - 16'd2;
        return {6'h04, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), imm};
      end
      7:       return {6'h02, 20'd0, 6'($urandom_range(0, 63))};
      8:       return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      default: return {6'h3F, 26'($urandom)};
    endcase
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;

    vecs[0]  = '{32'h00, 32'h00221820, 0, 3, 32'h00000008, 32'h04};
    vecs[1]  = '{32'h04, 32'h8C040000, 0, 4, 32'h0000000A, 32'h08};
    vecs[2]  = '{32'h08, 32'hAC030004, 1, 1, 32'h00000008, 32'h0C};
    vecs[3]  = '{32'h0C, 32'h10210002, 2, 0, 32'h0,        32'h18};
    vecs[4]  = '{32'h18, 32'h0041282A, 0, 5, 32'h00000001, 32'h1C};
    vecs[5]  = '{32'h1C, 32'h00413022, 0, 6, 32'hFFFFFFFE, 32'h20};
    vecs[6]  = '{32'h20, 32'h10220002, 2, 0, 32'h0,        32'h24};
    vecs[7]  = '{32'h24, 32'h00220020, 0, 0, 32'h00000000, 32'h28};
    vecs[8]  = '{32'h28, 32'h00000000, 2, 0, 32'h0,        32'h2C};
    vecs[9]  = '{32'h2C, 32'h2027FFFF, 0, 7, 32'h00000004, 32'h30};
    vecs[10] = '{32'h30, 32'h08000000, 2, 0, 32'h0,        32'h00};

    clear_all();
    foreach (vecs[i]) dut.instmem_0.Mem[vecs[i].addr >> 2] = vecs[i].instr;
    dut.regfile_0.reg_mem[1] = 32'd5;
    dut.regfile_0.reg_mem[2] = 32'd3;
    dut.data_memory_0.Mem[0] = 32'h0000000A;

    applyStimulus();
    checkOutput("reset_pc", dut.pc_q, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus();
      if (vecs[i].kind == 0)
        checkOutput($sformatf("dir%0d_r%0d", i, vecs[i].idx), dut.regfile_0.reg_mem[vecs[i].idx], vecs[i].val);
      else if (vecs[i].kind == 1)
        checkOutput($sformatf("dir%0d_m%0d", i, vecs[i].idx), dut.data_memory_0.Mem[vecs[i].idx], vecs[i].val);
      checkOutput($sformatf("dir%0d_pc", i), dut.pc_q, vecs[i].pc);
    end
    checkOutput("nop_r0_file", dut.regfile_0.reg_mem[0], 32'd0);

    // Re-run the add at 0, then assert reset between edges
    applyStimulus();
    checkOutput("rerun_pc", dut.pc_q, 32'h04);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_pc", dut.pc_q, 32'd0);
    applyStimulus();
    checkOutput("held_reset_pc", dut.pc_q, 32'd0);
    checkOutput("keep_r3", dut.regfile_0.reg_mem[3], 32'd8);
    checkOutput("keep_m1", dut.data_memory_0.Mem[1], 32'd8);
    checkOutput("keep_r6", dut.regfile_0.reg_mem[6], 32'hFFFFFFFE);

    // Random programs against the model
    for (int p = 0; p < 4; p++) begin
      reset = 1'b1;
      clear_all();
      for (int i = 0; i < 64; i++) begin
        m_imem[i] = rand_instr();
        dut.instmem_0.Mem[i] = m_imem[i];
        m_dmem[i] = $urandom;
        dut.data_memory_0.Mem[i] = m_dmem[i];
      end
      for (int r = 1; r < 8; r++) begin
        m_reg[r] = (r < 4) ? 32'($urandom_range(0, 3)) : $urandom;
        dut.regfile_0.reg_mem[r] = m_reg[r];
      end
      m_pc = 32'd0;
      applyStimulus();
      reset = 1'b0;
      for (int s = 0; s < 60; s++) begin
        applyStimulus();
        model_step();
        checkOutput($sformatf("rnd%0d_s%0d_pc", p, s), dut.pc_q, m_pc);
        for (int r = 0; r < 8; r++)
          checkOutput($sformatf("rnd%0d_s%0d_r%0d", p, s, r), dut.regfile_0.reg_mem[r], m_reg[r]);
      end
      for (int i = 0; i < 64; i++)
        checkOutput($sformatf("rnd%0d_m%0d", p, i), dut.data_memory_0.Mem[i], m_dmem[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
